rr_grant_sched: RTL and testbench



---
 rtl/rr_sched_pkg.sv | 22 ++
 rtl/rr_grant_sched_if.sv | 30 +++
 rtl/rr_pick.sv | 35 +++
 rtl/rr_grant_sched.sv | 123 ++++++++++++
 tb/tb_rr_grant_sched.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
// Holds the FSM state encoding, hold-counter width and the index-to-one-hot helper.
package rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int HOLD_W = 8;
    localparam int MAX_N  = 16;

    // Callers size-cast the result down to their own requester count.
    function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_grant_sched_if.sv
// Request/grant bundle between requesters and the round-robin scheduler.
// The scheduler uses the slave modport; the requester side uses master.
interface rr_grant_sched_if #(
    parameter int N = 4
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_id;
    logic             busy;
    logic             preempt;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output busy,
        output preempt
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last+1.
// An optional excluded index is skipped so a releasing owner cannot re-win on the same edge.
module rr_pick #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    input  logic             i_exclude_valid,
    input  logic [IDX_W-1:0] i_exclude_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    int               w_j;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        w_cand  = '0;
        // k runs 1..N so last itself is checked last, giving it lowest priority.
        for (int k = 1; k <= N; k++) begin
            w_j    = (int'(i_last) + k) % N;
            w_cand = IDX_W'(w_j);
            if (!o_valid && i_req[w_cand] &&
                !(i_exclude_valid && (w_cand == i_exclude_idx))) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler: registered one-hot grant, held while the owner requests,
// with a forced release after MAX_HOLD cycles when others are waiting.
module rr_grant_sched
    import rr_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int GAP      = 1
) (
    input  logic            clk,
    input  logic            rst,
    rr_grant_sched_if.slave bus
);

    localparam int IDX_W = $clog2(N);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t              r_state;
    logic [N-1:0]        r_grant;
    logic [IDX_W-1:0]    r_grant_id;
    logic [IDX_W-1:0]    r_last;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic                r_preempt;

    state_t              w_state_nxt;
    logic [N-1:0]        w_grant_nxt;
    logic [IDX_W-1:0]    w_id_nxt;
    logic [IDX_W-1:0]    w_last_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                w_preempt_nxt;

    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_owner_req;
    logic                w_others_req;
    logic                w_in_grant;

    assign w_in_grant   = (r_state == ST_GRANT);
    assign w_owner_req  = bus.req[r_last];
    assign w_others_req = |(bus.req & ~r_grant);

    rr_pick #(.N(N)) u_pick (
        .i_req           (bus.req),
        .i_last          (r_last),
        .i_exclude_valid (w_in_grant),
        .i_exclude_idx   (r_last),
        .o_valid         (w_pick_valid),
        .o_idx           (w_pick_idx)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_id_nxt      = r_grant_id;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold_cnt;
        w_preempt_nxt = 1'b0;

        case (r_state)
            ST_GRANT: begin
                if (w_owner_req && ((r_hold_cnt < HOLD_MAX) || !w_others_req)) begin
                    if (r_hold_cnt != HOLD_MAX)
                        w_hold_nxt = r_hold_cnt + 1'b1;
                end else begin
                    // Owner still requesting here means the quantum forced it out.
                    w_preempt_nxt = w_owner_req;
                    w_grant_nxt   = '0;
                    w_id_nxt      = '0;
                    w_hold_nxt    = '0;
                    if (GAP == 1) begin
                        w_state_nxt = ST_GAP;
                    end else if (w_pick_valid) begin
                        w_state_nxt = ST_GRANT;
                        w_grant_nxt = N'(onehot(4'(w_pick_idx)));
                        w_id_nxt    = w_pick_idx;
                        w_last_nxt  = w_pick_idx;
                        w_hold_nxt  = HOLD_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; GAP only ever lasts one cycle.
                w_grant_nxt = '0;
                w_id_nxt    = '0;
                w_hold_nxt  = '0;
                w_state_nxt = ST_IDLE;
                if (w_pick_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = N'(onehot(4'(w_pick_idx)));
                    w_id_nxt    = w_pick_idx;
                    w_last_nxt  = w_pick_idx;
                    w_hold_nxt  = HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_last     <= IDX_W'(N - 1);
            r_hold_cnt <= '0;
            r_preempt  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_id_nxt;
            r_last     <= w_last_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_preempt  <= w_preempt_nxt;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = |r_grant;
    assign bus.preempt  = r_preempt;

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched: one GAP=1 instance and one GAP=0 instance,
// both N=4, MAX_HOLD=8, with hand-computed grant/preempt sequences.
module tb_rr_grant_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rr_grant_sched_if #(.N(4)) bus  ();
    rr_grant_sched_if #(.N(4)) bus0 ();

    rr_grant_sched #(.N(4), .MAX_HOLD(8), .GAP(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    rr_grant_sched #(.N(4), .MAX_HOLD(8), .GAP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic [3:0] g, input logic [1:0] id, input logic pre);
        check({tag, ".grant"},   32'(bus.grant),    32'(g));
        check({tag, ".id"},      32'(bus.grant_id), 32'(id));
        check({tag, ".busy"},    32'(bus.busy),     32'(|g));
        check({tag, ".preempt"}, 32'(bus.preempt),  32'(pre));
    endtask

    task automatic chk0(input string tag, input logic [3:0] g, input logic [1:0] id, input logic pre);
        check({tag, ".grant"},   32'(bus0.grant),    32'(g));
        check({tag, ".id"},      32'(bus0.grant_id), 32'(id));
        check({tag, ".busy"},    32'(bus0.busy),     32'(|g));
        check({tag, ".preempt"}, 32'(bus0.preempt),  32'(pre));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.req  = '0;
        bus0.req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] g;
        bus.req  = '0;
        bus0.req = '0;

        // reset state
        do_reset();
        rst = 1'b1;
        tick();
        chk1("reset", 4'b0000, 2'd0, 1'b0);
        chk0("reset0", 4'b0000, 2'd0, 1'b0);

        // single uncontended requester keeps grant, never preempted
        rst     = 1'b0;
        bus.req = 4'b0001;
        tick();
        chk1("solo_first", 4'b0001, 2'd0, 1'b0);
        for (int c = 0; c < 50; c++) begin
            tick();
            check("solo_grant", 32'(bus.grant), 32'(4'b0001));
            check("solo_pre", 32'(bus.preempt), 32'(1'b0));
        end
        // saturated hold meets contention: immediate forced release
        bus.req = 4'b0011;
        tick();
        chk1("sat_release", 4'b0000, 2'd0, 1'b1);
        tick();
        chk1("sat_next", 4'b0010, 2'd1, 1'b0);

        // two constant requesters: 8 cycles each, preempt gap between
        do_reset();
        bus.req = 4'b0011;
        for (int c = 0; c < 27; c++) begin
            tick();
            if ((c % 9) < 8) begin
                if (((c / 9) % 2) == 1) chk1("rr2_hold", 4'b0010, 2'd1, 1'b0);
                else                    chk1("rr2_hold", 4'b0001, 2'd0, 1'b0);
            end else begin
                chk1("rr2_gap", 4'b0000, 2'd0, 1'b1);
            end
        end

        // four requesters, each owner releases after 3 cycles
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            for (int h = 0; h < 3; h++) begin
                tick();
                chk1("rr4_hold", g, 2'(k % 4), 1'b0);
            end
            bus.req = 4'b1111 & ~g;
            tick();
            chk1("rr4_gap", 4'b0000, 2'd0, 1'b0);
            bus.req = 4'b1111;
        end

        // owner drops exactly as its quantum expires: normal release
        do_reset();
        bus.req = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk1("qdrop_hold", 4'b0001, 2'd0, 1'b0);
        end
        bus.req = 4'b0100;
        tick();
        chk1("qdrop_rel", 4'b0000, 2'd0, 1'b0);
        tick();
        chk1("qdrop_next", 4'b0100, 2'd2, 1'b0);

        // GAP=0: normal release hands over on the very next edge
        do_reset();
        bus0.req = 4'b0101;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk0("g0_hold", 4'b0001, 2'd0, 1'b0);
        end
        bus0.req = 4'b0100;
        tick();
        chk0("g0_handover", 4'b0100, 2'd2, 1'b0);

        // GAP=0: forced release hands over directly with preempt
        do_reset();
        bus0.req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk0("g0f_hold", 4'b0001, 2'd0, 1'b0);
        end
        tick();
        chk0("g0f_pre", 4'b0010, 2'd1, 1'b1);
        tick();
        chk0("g0f_after", 4'b0010, 2'd1, 1'b0);

        // reset during a grant, then last restarts at N-1
        do_reset();
        bus.req = 4'b0010;
        tick();
        chk1("rstmid_pre", 4'b0010, 2'd1, 1'b0);
        rst = 1'b1;
        tick();
        chk1("rstmid_drop", 4'b0000, 2'd0, 1'b0);
        rst     = 1'b0;
        bus.req = 4'b0110;
        tick();
        chk1("rstmid_first", 4'b0010, 2'd1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
